// File: rtl/mux4x1_ot_pkg.sv
// Shared types and constants for the mux4x1_ot select/data path.
package mux4x1_ot_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/mux4x1_ot_core.sv
// Purely combinational 4:1 selector; an unknown select yields an unknown output.
module mux4x1_ot_core
  import mux4x1_ot_pkg::*;
(
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  sel_t sel,
  output logic y
);

  // An X/Z select matches no item, so y stays X rather than falling back to an input.
  always_comb begin
    y = 1'bx;
    case (sel)
      SEL_I0:  y = I0;
      SEL_I1:  y = I1;
      SEL_I2:  y = I2;
      SEL_I3:  y = I3;
      default: y = 1'bx;
    endcase
  end

endmodule

// File: rtl/mux4x1_ot.sv
// 4:1 mux with registered output/select and an optional select-change pulse and
// saturating change counter, enabled by macro MUX4X1_OT_CHG_CNT_EN.
module mux4x1_ot
  import mux4x1_ot_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I0,
  input  logic             I1,
  input  logic             I2,
  input  logic             I3,
  input  logic             S1,
  input  logic             S0,
  output logic             y,
  output logic             y_q,
  output logic [1:0]       sel_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  sel_t sel_d;
  logic y_d;

  mux4x1_ot_core u_core (
    .I0  (I0),
    .I1  (I1),
    .I2  (I2),
    .I3  (I3),
    .sel (sel_d),
    .y   (y)
  );

  always_comb begin
    sel_d = {S1, S0};
    y_d   = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 1'b0;
      sel_q <= SEL_I0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX4X1_OT_CHG_CNT_EN
  logic             sel_chg_d, sel_chg_q;
  logic [CNT_W-1:0] chg_cnt_d, chg_cnt_q;

  // sel_q resets to 00, so a non-zero select on the first edge counts as a change.
  always_comb begin
    sel_chg_d = (sel_d != sel_q);
    chg_cnt_d = chg_cnt_q;
    if (sel_chg_d && (chg_cnt_q != '1)) begin
      chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_chg_q <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      sel_chg_q <= sel_chg_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign sel_chg = sel_chg_q;
  assign chg_cnt = chg_cnt_q;
`else
  assign sel_chg = 1'b0;
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_mux4x1_ot.sv
// Self-checking bench for mux4x1_ot (CNT_W=2), expectations from a reference model.
module tb_mux4x1_ot;

  localparam int unsigned CW  = 2;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [3:0]    din;
  logic [1:0]    sel;
  logic          y, y_q, sel_chg;
  logic [1:0]    sel_q;
  logic [CW-1:0] chg_cnt;

  int checks = 0;
  int errors = 0;

`ifdef MUX4X1_OT_CHG_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  mux4x1_ot #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .I0      (din[0]),
    .I1      (din[1]),
    .I2      (din[2]),
    .I3      (din[3]),
    .S1      (sel[1]),
    .S0      (sel[0]),
    .y       (y),
    .y_q     (y_q),
    .sel_q   (sel_q),
    .sel_chg (sel_chg),
    .chg_cnt (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the selected input is din[sel]; the counter is the number of
  // select changes since reset, clipped at MAX.
  logic       m_yq;
  logic [1:0] m_sel;
  logic       m_chg;
  int         m_nchg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_yq   <= 1'b0;
      m_sel  <= 2'd0;
      m_chg  <= 1'b0;
      m_nchg <= 0;
    end else begin
      m_yq   <= din[sel];
      m_sel  <= sel;
      m_chg  <= (sel != m_sel);
      m_nchg <= m_nchg + ((sel != m_sel) ? 1 : 0);
    end
  end

  function automatic int exp_cnt();
    if (!CNT_ON) return 0;
    return (m_nchg > MAX) ? MAX : m_nchg;
  endfunction

  function automatic logic exp_chg();
    return CNT_ON ? m_chg : 1'b0;
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 4'b1010; sel = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({y_q, sel_q, sel_chg, 32'(chg_cnt)} !== {1'b0, 2'b00, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got y_q=%b sel_q=%b sel_chg=%b chg_cnt=%0d want 0/00/0/0",
               y_q, sel_q, sel_chg, chg_cnt);
    end
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL reset_y_comb: got %b want 1", y);
    end
    rst = 1'b0;
  endtask

  task automatic test_sel_sweep();
    logic [3:0] want;
    want = 4'b1101;
    din  = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #0;
      #1;
      checks++;
      if (y !== want[i]) begin
        errors++;
        $display("FAIL sel_sweep sel=%0d: got %b want %b", i, y, want[i]);
      end
      #9;
    end
  endtask

  task automatic test_data_sweep();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      din = 4'b0000;
      for (int v = 0; v < 3; v++) begin
        din[s] = (v == 1);
        #1;
        checks++;
        if (y !== (v == 1)) begin
          errors++;
          $display("FAIL data_sel sel=%0d step=%0d: got %b want %b", s, v, y, (v == 1));
        end
      end
      for (int o = 0; o < 4; o++) begin
        if (o != s) begin
          din[o] = 1'b1;
          #1;
          checks++;
          if (y !== 1'b0) begin
            errors++;
            $display("FAIL data_other sel=%0d in=%0d: got %b want 0", s, o, y);
          end
          din[o] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_registered();
    din = 4'b0100; sel = 2'b00;
    do_reset();
    @(posedge clk); #1;
    sel = 2'b10;
    #1;
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL reg_y_now: got %b want 1", y);
    end
    @(posedge clk); #1;
    checks++;
    if ({y_q, sel_q, sel_chg, 32'(chg_cnt)} !== {1'b1, 2'b10, CNT_ON, CNT_ON ? 32'd1 : 32'd0}) begin
      errors++;
      $display("FAIL reg_edge_n: got y_q=%b sel_q=%b sel_chg=%b chg_cnt=%0d want 1/10/%b/%0d",
               y_q, sel_q, sel_chg, chg_cnt, CNT_ON, CNT_ON ? 1 : 0);
    end
    @(posedge clk); #1;
    checks++;
    if ({sel_chg, 32'(chg_cnt)} !== {1'b0, CNT_ON ? 32'd1 : 32'd0}) begin
      errors++;
      $display("FAIL reg_edge_n1: got sel_chg=%b chg_cnt=%0d want 0/%0d",
               sel_chg, chg_cnt, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_saturation();
    int want [6] = '{1, 2, 3, 3, 3, 3};
    din = 4'b0011; sel = 2'b00;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      sel = (c % 2 == 0) ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      checks++;
      if ({sel_chg, 32'(chg_cnt)} !== {CNT_ON, CNT_ON ? 32'(want[c]) : 32'd0}) begin
        errors++;
        $display("FAIL saturation c=%0d: got sel_chg=%b chg_cnt=%0d want %b/%0d",
                 c, sel_chg, chg_cnt, CNT_ON, CNT_ON ? want[c] : 0);
      end
    end
  endtask

  task automatic test_async_reset();
    // Continues from saturation: counter at max, select 00, I0=1 so y_q=1.
    @(posedge clk); #1;
    checks++;
    if ({y_q, 32'(chg_cnt)} !== {1'b1, CNT_ON ? 32'(MAX) : 32'd0}) begin
      errors++;
      $display("FAIL async_pre: got y_q=%b chg_cnt=%0d want 1/%0d", y_q, chg_cnt, CNT_ON ? MAX : 0);
    end
    sel = 2'b11;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({y_q, sel_q, sel_chg, 32'(chg_cnt)} !== {1'b0, 2'b00, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL async_clear: got y_q=%b sel_q=%b sel_chg=%b chg_cnt=%0d want 0/00/0/0",
               y_q, sel_q, sel_chg, chg_cnt);
    end
    din[3] = 1'b1;
    #1;
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL async_y_track: got %b want 1", y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({y_q, sel_q, sel_chg, 32'(chg_cnt)} !== {1'b1, 2'b11, CNT_ON, CNT_ON ? 32'd1 : 32'd0}) begin
      errors++;
      $display("FAIL resume_first_edge: got y_q=%b sel_q=%b sel_chg=%b chg_cnt=%0d want 1/11/%b/%0d",
               y_q, sel_q, sel_chg, chg_cnt, CNT_ON, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      din = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      #1;
      checks++;
      if (y !== din[sel]) begin
        errors++;
        $display("FAIL rand_y n=%0d: got %b want %b", n, y, din[sel]);
      end
      @(posedge clk); #1;
      checks++;
      if ({y_q, sel_q, sel_chg, 32'(chg_cnt)} !== {m_yq, m_sel, exp_chg(), 32'(exp_cnt())}) begin
        errors++;
        $display("FAIL rand_reg n=%0d: got y_q=%b sel_q=%b sel_chg=%b chg_cnt=%0d want %b/%b/%b/%0d",
                 n, y_q, sel_q, sel_chg, chg_cnt, m_yq, m_sel, exp_chg(), exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sel_sweep();
    test_data_sweep();
    test_registered();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
